inverse_ej4: RTL

//   Inverse (equalising) filter for the improved_ej4 IIR datapath. Takes the filtered

---
 rtl/inverse_ej4.sv | 97 +++++++++
 1 files changed

// File: rtl/inverse_ej4.sv
// Inverse (equalising) filter for the improved_ej4 IIR: recovers X from the filtered
// stream Y one valid sample at a time, with output clamping and a sticky sat flag.
module inverse_ej4 #(
   parameter int NBinput  = 8,
   parameter int NBoutput = 8,
   parameter int b1       = -1,
   parameter int b2       = 1,
   parameter int b3       = 1,
   parameter int A1_SH    = 2,
   parameter int A2_SH    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       in_valid,
   input  logic signed [NBinput-1:0]  Y,
   output logic                       out_valid,
   output logic signed [NBoutput-1:0] X,
   output logic                       sat
);

   localparam int ACC = ((NBinput > NBoutput) ? NBinput : NBoutput) + 4;
   localparam logic signed [ACC-1:0] XMAX = ACC'((2 ** (NBoutput - 1)) - 1);
   localparam logic signed [ACC-1:0] XMIN = ACC'(-(2 ** (NBoutput - 1)));

   logic signed [NBinput-1:0]  yh_q [2];
   logic signed [NBinput-1:0]  yh_d [2];
   logic signed [NBoutput-1:0] xh_q [3];
   logic signed [NBoutput-1:0] xh_d [3];
   logic                       out_valid_q, out_valid_d;
   logic                       sat_q, sat_d;

   logic signed [ACC-1:0] y0e, y1e, y2e, x1e, x2e, x3e, sum;
   logic                  hi, lo;
   logic signed [NBoutput-1:0] xn;

   always_comb begin
      y0e = {{(ACC-NBinput){Y[NBinput-1]}}, Y};
      y1e = {{(ACC-NBinput){yh_q[0][NBinput-1]}}, yh_q[0]};
      y2e = {{(ACC-NBinput){yh_q[1][NBinput-1]}}, yh_q[1]};
      x1e = {{(ACC-NBoutput){xh_q[0][NBoutput-1]}}, xh_q[0]};
      x2e = {{(ACC-NBoutput){xh_q[1][NBoutput-1]}}, xh_q[1]};
      x3e = {{(ACC-NBoutput){xh_q[2][NBoutput-1]}}, xh_q[2]};

      // b taps are +/-1: subtracting b*x is an add or a subtract of x
      sum = y0e - (y1e >>> A1_SH) - (y2e >>> A2_SH);
      sum = (b1 == 1) ? (sum - x1e) : (sum + x1e);
      sum = (b2 == 1) ? (sum - x2e) : (sum + x2e);
      sum = (b3 == 1) ? (sum - x3e) : (sum + x3e);

      hi = (sum > XMAX);
      lo = (sum < XMIN);
      if (hi)      xn = XMAX[NBoutput-1:0];
      else if (lo) xn = XMIN[NBoutput-1:0];
      else         xn = sum[NBoutput-1:0];
   end

   always_comb begin
      yh_d        = yh_q;
      xh_d        = xh_q;
      sat_d       = sat_q;
      out_valid_d = 1'b0;
      if (clr) begin
         yh_d  = '{default: '0};
         xh_d  = '{default: '0};
         sat_d = 1'b0;
      end else if (in_valid) begin
         yh_d[1]     = yh_q[0];
         yh_d[0]     = Y;
         xh_d[2]     = xh_q[1];
         xh_d[1]     = xh_q[0];
         xh_d[0]     = xn;
         sat_d       = sat_q | hi | lo;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yh_q        <= '{default: '0};
         xh_q        <= '{default: '0};
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         yh_q        <= yh_d;
         xh_q        <= xh_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   // newest X history entry doubles as the output register
   assign X         = xh_q[0];
   assign out_valid = out_valid_q;
   assign sat       = sat_q;

endmodule
